// File: rtl/uart_rx_fifo.sv
// Receive byte buffer between the UART receiver and the CPU I/O read path.
// A three-state ingest FSM drains the UART; the CPU sees the head entry combinationally.
module uart_rx_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [DW-1:0] rx_data,
  output logic          rx_rd,
  input  logic          pop,
  input  logic          clr_ovf,
  output logic [DW-1:0] dout,
  output logic          nonempty,
  output logic          full,
  output logic          overflow,
  output logic [AW:0]   level
);

  localparam int          DEPTH_I = 1 << AW;
  localparam logic [AW:0] DEPTH   = DEPTH_I[AW:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   mem_q [DEPTH_I];
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   rp_q, rp_d;
  logic [AW:0]     level_q, level_d;
  logic            ovf_q, ovf_d;
  logic            rd_q;
  logic            wr_en;
  logic            drop;
  logic            pop_en;

  assign dout     = mem_q[rp_q];
  assign nonempty = (level_q != '0);
  assign full     = (level_q == DEPTH);
  assign overflow = ovf_q;
  assign level    = level_q;
  assign rx_rd    = rd_q;

  // Full is judged at the start of the ACK cycle; a same-cycle pop cannot make room.
  assign wr_en  = (state_q == ACK) && !full;
  assign drop   = (state_q == ACK) && full;
  assign pop_en = pop && nonempty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_valid) state_d = ACK;
      ACK:     state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (wr_en)  wp_d = wp_q + AW'(1);
    if (pop_en) rp_d = rp_q + AW'(1);
    case ({wr_en, pop_en})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      rd_q    <= (state_d == ACK);
    end
  end

  // Storage is not reset; a reset landing in ACK must still suppress the write.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wp_q] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a monitor checks each pop.
module tb_uart_rx_fifo;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset, rx_valid, pop, clr_ovf;
  logic [DW-1:0] rx_data;
  logic          rx_rd, nonempty, full, overflow;
  logic [DW-1:0] dout;
  logic [AW:0]   level;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int mdl_lvl = 0, mdl_wr = 0, mdl_rd = 0;
  int rd_cnt = 0, exp_rd = 0;
  logic rd_prev = 1'b0;

  uart_rx_fifo #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd(rx_rd),
    .pop(pop), .clr_ovf(clr_ovf), .dout(dout), .nonempty(nonempty), .full(full),
    .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares the head byte on every effective pop, and checks rx_rd pulse width.
  always @(negedge clk) begin
    if (pop && nonempty) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_dout: got %0h expected no entry", dout);
      end else begin
        exp_b = exp_q.pop_front();
        mdl_rd++;
        if (dout !== exp_b) begin
          n_fail++;
          $display("FAIL pop_dout: got %0h expected %0h", dout, exp_b);
        end
      end
    end
    if (rx_rd) begin
      rd_cnt++;
      n_cmp++;
      if (rd_prev) begin
        n_fail++;
        $display("FAIL rx_rd_width: got 2+ cycles expected 1");
      end
    end
    rd_prev = rx_rd;
  end

  task automatic do_reset();
    reset = 1'b1; rx_valid = 1'b0; pop = 1'b0; clr_ovf = 1'b0; rx_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    mdl_lvl = 0; mdl_wr = 0; mdl_rd = 0;
  endtask

  // Offer one byte; optionally pop during the ACK cycle. Called at posedge+1.
  task automatic send(input logic [7:0] b, input bit pop_ack);
    int t;
    int lv0;
    bit acc, pv;
    rx_valid = 1'b1; rx_data = b; t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (!rx_rd && t < 10);
    exp_rd++;
    rx_valid = 1'b0;
    if (!rx_rd) begin
      n_cmp++; n_fail++;
      $display("FAIL rx_rd_timeout: got no pulse expected pulse for %0h", b);
      return;
    end
    lv0 = mdl_lvl;
    acc = (lv0 < 16);
    pv  = pop_ack && (lv0 > 0);
    if (acc) begin exp_q.push_back(b); mdl_wr++; end
    mdl_lvl = lv0 + int'(acc) - int'(pv);
    if (pop_ack) pop = 1'b1;
    @(posedge clk); #1 pop = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_pop(input int n);
    repeat (n) begin
      pop = 1'b1;
      if (mdl_lvl > 0) mdl_lvl--;
      @(posedge clk); #1 pop = 1'b0;
    end
  endtask

  task automatic clear_ovf();
    clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
  endtask

  initial begin
    int t;
    do_reset();
    chk("rst_rx_rd", rx_rd, 0);
    chk("rst_nonempty", nonempty, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_level", level, 0);

    // Single byte, precise latency
    rx_valid = 1'b1; rx_data = 8'h41;
    @(negedge clk) chk("t1_rd_early", rx_rd, 0);
    @(posedge clk); #1;
    chk("t1_rd_pulse", rx_rd, 1);
    rx_valid = 1'b0;
    exp_q.push_back(8'h41); mdl_wr++; mdl_lvl = 1; exp_rd++;
    chk("t1_level_ack", level, 0);
    @(posedge clk); #1;
    chk("t1_rd_low", rx_rd, 0);
    chk("t1_nonempty", nonempty, 1);
    chk("t1_dout", dout, 8'h41);
    chk("t1_level", level, 1);
    @(posedge clk); #1;
    chk("t1_idle", 32'(dut.state_q), 0);
    do_pop(1);
    chk("t1_level_pop", level, 0);

    // Fill 00..0F, drain in order, pointers wrap
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    chk("t2_full", full, 1);
    chk("t2_level", level, 16);
    do_pop(16);
    chk("t2_nonempty", nonempty, 0);
    chk("t2_wp", 32'(dut.wp_q), 0);
    chk("t2_rp", 32'(dut.rp_q), 0);

    // Overflow on a full FIFO
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    send(8'h99, 1'b0);
    chk("t3_overflow", overflow, 1);
    chk("t3_level", level, 16);
    chk("t3_head", dout, 8'h00);
    clear_ovf();
    chk("t3_ovf_clr", overflow, 0);

    // Pop in the ACK cycle does not rescue a write to a full FIFO
    send(8'h55, 1'b1);
    chk("t4_overflow", overflow, 1);
    chk("t4_level", level, 15);
    chk("t4_head", dout, 8'h01);
    clear_ovf();

    // Coincident accepted write and pop
    do_pop(12);
    chk("t5_level_pre", level, 3);
    send(8'hAA, 1'b1);
    chk("t5_level", level, 3);
    chk("t5_overflow", overflow, 0);
    do_pop(3);
    chk("t5_level_end", level, 0);
    chk("t5_sb_empty", exp_q.size(), 0);

    // Pop on empty is ignored
    do_pop(1);
    chk("t6_level", level, 0);
    chk("t6_wp", 32'(dut.wp_q), mdl_wr % 16);
    chk("t6_rp", 32'(dut.rp_q), mdl_rd % 16);
    chk("t6_overflow", overflow, 0);

    // Reset landing in ACK
    rx_valid = 1'b1; rx_data = 8'h77; t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (!rx_rd && t < 10);
    exp_rd++;
    chk("t7_in_ack", 32'(dut.state_q), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; rx_valid = 1'b0;
    exp_q.delete(); mdl_lvl = 0; mdl_wr = 0; mdl_rd = 0;
    chk("t7_rx_rd", rx_rd, 0);
    chk("t7_level", level, 0);
    chk("t7_nonempty", nonempty, 0);
    chk("t7_idle", 32'(dut.state_q), 0);
    @(posedge clk); #1;
    chk("t7_still_empty", level, 0);

    chk("rd_pulse_count", rd_cnt, exp_rd);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the `buart` receiver and the j1 I/O read path. It drains received bytes from the UART as soon as they appear, acknowledging each with a one-cycle `rx_rd` pulse, and stores them in a small FIFO. The CPU reads the head byte combinationally and pops it with an I/O strobe. Firmware can therefore absorb bursts at 115200 baud without polling every character time.

## Interface

Parameters:
- `AW`, 4: FIFO address width; depth = 2^AW entries (16).
- `DW`, 8: data width in bits.

Ports:
- `clk` in 1: system clock (`fclk`); all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `rx_valid` in 1: the UART holds a received byte; stays high until acknowledged.
- `rx_data` in DW: the received byte; stable while `rx_valid` is high.
- `rx_rd` out 1: acknowledge pulse to the UART `rd` input; one cycle, registered.
- `pop` in 1: CPU read strobe (decoded, registered I/O access); removes the head entry.
- `clr_ovf` in 1: clears the `overflow` flag.
- `dout` out DW: head entry; meaningful only while `nonempty` is high.
- `nonempty` out 1: FIFO holds at least 1 entry.
- `full` out 1: FIFO holds 2^AW entries.
- `overflow` out 1: sticky flag; a byte was dropped because the FIFO was full.
- `level` out AW+1: current entry count, 0..2^AW.

## Operation

- Storage is a register array of 2^AW x DW, with write pointer `wp` and read pointer `rp`, each AW bits wide. Both pointers wrap modulo 2^AW. `level` is a separate AW+1-bit counter.
- `dout` = `mem[rp]` (first-word-fall-through). `nonempty` = (`level` != 0). `full` = (`level` == 2^AW).
- The ingest FSM has 3 states:
  - IDLE: if `rx_valid`, go to ACK.
  - ACK: `rx_rd` = 1. `rx_data` is captured this cycle. If not full, write `mem[wp]` and increment `wp`. If full, drop the byte and set `overflow`. Go to HOLD.
  - HOLD: `rx_rd` = 0. This cycle is a holdoff so the UART's `valid` can fall. Go to IDLE unconditionally.
- The full test in ACK uses `full` as it stands at the start of the cycle. A pop in the same cycle does not rescue the write.
- Pop:
  - If `pop` and `nonempty`, increment `rp`.
  - If `pop` while empty, the strobe is ignored: no pointer change and no error flag.
- `level` update:
  - +1 on an accepted write only.
  - -1 on a valid pop only.
  - Unchanged when both occur in the same cycle.
- `overflow`:
  - Set on a dropped byte.
  - Cleared by `clr_ovf`.
  - If set and clear occur in the same cycle, set wins.
- Reset values: `rx_rd`=0, `nonempty`=0, `full`=0, `overflow`=0, `level`=0, `wp`=`rp`=0, FSM=IDLE. Array contents are not reset, so `dout` is don't-care after reset.
- Reset mid-operation (any state): all of the above values are restored at that edge. Any byte in flight is lost. If reset lands in ACK, the byte is not written.

## Timing

- `rx_valid` sampled high at the edge ending cycle N:
  - `rx_rd` = 1 during N+1.
  - Byte is written at the edge ending N+1.
  - `nonempty` = 1 and `dout` = byte during N+2.
  - HOLD during N+2; IDLE during N+3.
- Peak ingest rate: 1 byte per 3 cycles, far above the UART rate.
- Pop: `pop` high during cycle M. The next entry appears on `dout` and `level` decrements during M+1.
- There is no combinational path from `rx_valid`, `pop` or `clr_ovf` to `rx_rd`. `dout`, `nonempty`, `full` and `level` depend only on registers.

## Test plan

- Reset, then hold `rx_valid`=1 with `rx_data`=8'h41 for 2 cycles, dropping it on the `rx_rd` cycle:
  - exactly one `rx_rd` pulse, 1 cycle after `rx_valid` first samples high;
  - `nonempty`=1, `dout`=8'h41, `level`=1 two cycles after `rx_valid` rises.
- Ingest 8'h00..8'h0F, then pop 16 times:
  - `dout` sequence is 00..0F;
  - `full`=1 at `level`=16;
  - `nonempty`=0 after the last pop;
  - `wp` and `rp` have both wrapped to 0.
- Fill to 16, then offer 8'h99:
  - `rx_rd` still pulses;
  - `overflow`=1, `level` stays 16;
  - head is still 8'h00.
  - `clr_ovf` for 1 cycle -> `overflow`=0.
- `level`=16, `pop` asserted in the ACK cycle of byte 8'h55:
  - byte is dropped and `overflow`=1;
  - `level`=15;
  - `dout` advances to 8'h01.
- `level`=3, `pop` coincident with an accepted write of 8'hAA:
  - `level` stays 3;
  - 8'hAA appears after 3 further pops.
- Pop on empty -> `level`=0, pointers unchanged. Assert `reset` during ACK -> next cycle `rx_rd`=0, `level`=0, `nonempty`=0, FSM IDLE.
